// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, bias and canned encodings for the FP multiply path.
package fp32_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even, overflow/flush-to-zero and special-case packing for the
// normalized product held in the first pipeline stage.
module fp_round_rne import fp32_pkg::*; #(
    parameter int EXP_W  = fp32_pkg::EXP_W,
    parameter int MANT_W = fp32_pkg::MANT_W,
    parameter int BIAS   = fp32_pkg::BIAS
) (
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] exp_val,
    input  logic [MANT_W-1:0]       frac,
    input  logic                    guard,
    input  logic                    sticky,
    input  logic                    nan,
    input  logic                    inf,
    input  logic                    zero,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);
    localparam int RES_W = EXP_W + MANT_W + 1;
    // All-ones exponent (inf/NaN encoding) is 2*BIAS+1.
    localparam logic [EXP_W:0] EXP_MAX = (EXP_W+1)'(2 * BIAS + 1);

    logic                    inc;
    logic [MANT_W:0]         frac_inc;
    logic signed [EXP_W+1:0] exp_r;
    logic                    exp_ovf;
    logic                    exp_unf;

    assign inc      = guard && (sticky || frac[0]);
    assign frac_inc = {1'b0, frac} + {{MANT_W{1'b0}}, inc};
    // A carry out of the fraction leaves the fraction bits zero and bumps the exponent.
    assign exp_r    = exp_val + $signed({{(EXP_W+1){1'b0}}, frac_inc[MANT_W]});
    assign exp_ovf  = !exp_r[EXP_W+1] && (exp_r[EXP_W:0] >= EXP_MAX);
    assign exp_unf  = exp_r[EXP_W+1] || (exp_r == '0);

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = 1'b0;
        if (nan) begin
            result = RES_W'(QNAN);
        end else if (inf) begin
            result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (zero) begin
            result = {sign, {(RES_W-1){1'b0}}};
        end else if (exp_ovf) begin
            result   = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            overflow = 1'b1;
            inexact  = 1'b1;
        end else if (exp_unf) begin
            result    = {sign, {(RES_W-1){1'b0}}};
            underflow = 1'b1;
            inexact   = 1'b1;
        end else begin
            result  = {sign, exp_r[EXP_W-1:0], frac_inc[MANT_W-1:0]};
            inexact = guard || sticky;
        end
    end
endmodule

// File: rtl/fp_mul_norm_round.sv
// Two-stage normalize / round-and-pack pipeline behind the significand multiplier,
// with valid/ready flow control on both sides.
module fp_mul_norm_round import fp32_pkg::*; #(
    parameter int EXP_W  = fp32_pkg::EXP_W,
    parameter int MANT_W = fp32_pkg::MANT_W,
    parameter int BIAS   = fp32_pkg::BIAS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        sign_in,
    input  logic signed [EXP_W+1:0]     exp_sum_in,
    input  logic [2*(MANT_W+1)-1:0]     mant_prod_in,
    input  logic                        nan_in,
    input  logic                        inf_in,
    input  logic                        zero_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W+MANT_W:0]       result_out,
    output logic                        overflow_out,
    output logic                        underflow_out,
    output logic                        inexact_out
);
    localparam int PROD_W = 2 * (MANT_W + 1);
    localparam int RES_W  = EXP_W + MANT_W + 1;

    logic                    s1_load;
    logic                    s2_load;

    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [EXP_W+1:0] s1_exp;
    logic [MANT_W-1:0]       s1_frac;
    logic                    s1_guard;
    logic                    s1_sticky;
    logic                    s1_nan;
    logic                    s1_inf;
    logic                    s1_zero;

    logic                    s2_valid;

    logic [MANT_W-1:0]       n_frac;
    logic                    n_guard;
    logic                    n_sticky;
    logic signed [EXP_W+1:0] n_exp;

    logic [RES_W-1:0]        r_result;
    logic                    r_overflow;
    logic                    r_underflow;
    logic                    r_inexact;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    // Masked during reset so nothing downstream can complete a transfer that cycle.
    assign out_valid = s2_valid && !rst;

    // Significand product lies in [1,4); a set top bit means one extra binade.
    always_comb begin
        if (mant_prod_in[PROD_W-1]) begin
            n_frac   = mant_prod_in[PROD_W-2 -: MANT_W];
            n_guard  = mant_prod_in[MANT_W];
            n_sticky = |mant_prod_in[MANT_W-1:0];
            n_exp    = exp_sum_in + $signed((EXP_W+2)'(1));
        end else begin
            n_frac   = mant_prod_in[PROD_W-3 -: MANT_W];
            n_guard  = mant_prod_in[MANT_W-1];
            n_sticky = |mant_prod_in[MANT_W-2:0];
            n_exp    = exp_sum_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_frac   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= sign_in;
                s1_exp    <= n_exp;
                s1_frac   <= n_frac;
                s1_guard  <= n_guard;
                s1_sticky <= n_sticky;
                s1_nan    <= nan_in;
                s1_inf    <= inf_in;
                s1_zero   <= zero_in;
            end
        end
    end

    fp_round_rne #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .BIAS   (BIAS)
    ) u_round (
        .sign      (s1_sign),
        .exp_val   (s1_exp),
        .frac      (s1_frac),
        .guard     (s1_guard),
        .sticky    (s1_sticky),
        .nan       (s1_nan),
        .inf       (s1_inf),
        .zero      (s1_zero),
        .result    (r_result),
        .overflow  (r_overflow),
        .underflow (r_underflow),
        .inexact   (r_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            result_out    <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
            inexact_out   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_out    <= r_result;
                overflow_out  <= r_overflow;
                underflow_out <= r_underflow;
                inexact_out   <= r_inexact;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed vectors, backpressure/reset sequences and a randomized stream checked
// against an arithmetic reference model of the normalize/round/pack rules.
module tb_fp_mul_norm_round;
    import fp32_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               sign_in = 1'b0;
    logic signed [9:0]  exp_sum_in = '0;
    logic [47:0]        mant_prod_in = '0;
    logic               nan_in = 1'b0;
    logic               inf_in = 1'b0;
    logic               zero_in = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        result_out;
    logic               overflow_out;
    logic               underflow_out;
    logic               inexact_out;

    fp_mul_norm_round dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sign_in       (sign_in),
        .exp_sum_in    (exp_sum_in),
        .mant_prod_in  (mant_prod_in),
        .nan_in        (nan_in),
        .inf_in        (inf_in),
        .zero_in       (zero_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result_out    (result_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out),
        .inexact_out   (inexact_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              sign;
        logic signed [9:0] exp_sum;
        logic [47:0]       p;
        logic              nan;
        logic              inf;
        logic              zero;
        logic [31:0]       res;
        logic              ov;
        logic              un;
        logic              ix;
    } vec_t;

    localparam int NV = 13;
    localparam int NR = 300;

    vec_t        vecs [NV];
    logic [34:0] sb [$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input logic vld);
        in_valid     = vld;
        sign_in      = v.sign;
        exp_sum_in   = v.exp_sum;
        mant_prod_in = v.p;
        nan_in       = v.nan;
        inf_in       = v.inf;
        zero_in      = v.zero;
    endtask

    // Value-level model: significand = P / 2^46, scaled to a 24-bit integer with
    // the discarded remainder compared against one half for nearest-even.
    function automatic logic [34:0] model(input logic sgn, input int es, input logic [47:0] p,
                                          input logic nan, input logic inf, input logic zero);
        fp32_t           r;
        longint unsigned q, rem, half;
        int              sh, e;
        logic            ov, un, ix, up;
        r  = '0;
        ov = 0; un = 0; ix = 0;
        if (nan) begin
            r = QNAN;
        end else if (inf) begin
            r.sign = sgn; r.exp = 8'hFF;
        end else if (zero) begin
            r.sign = sgn;
        end else begin
            sh   = p[47] ? 24 : 23;
            q    = 64'(p) >> sh;
            rem  = 64'(p) - (q << sh);
            half = 64'd1 << (sh - 1);
            up   = (rem > half) || (rem == half && q[0]);
            ix   = (rem != 0);
            q    = q + 64'(up);
            e    = es + (p[47] ? 1 : 0);
            if (q >= (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            r.sign = sgn;
            if (e >= 255) begin
                r.exp = 8'hFF; ov = 1; ix = 1;
            end else if (e <= 0) begin
                un = 1; ix = 1;
            end else begin
                r.exp  = 8'(e);
                r.frac = q[22:0];
            end
        end
        return {r, ov, un, ix};
    endfunction

    initial begin
        int          lat;
        bit          seen;
        int          idx;
        int          sent, got, cyc, es, sel;
        bit          accepted;
        logic [34:0] expv;
        logic [47:0] pa, pb;
        vec_t        rv;

        vecs[0]  = '{1'b0, 10'sd127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 10'sd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 10'sd127, 48'h400000C00000, 1'b0, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 10'sd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 10'sd0,   48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 10'sd127, 48'hFFFFFF800000, 1'b0, 1'b0, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 10'sd127, 48'h000000000000, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 10'sd127, 48'h800000000000, 1'b0, 1'b1, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 10'sd127, 48'h000000000000, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 10'sd253, 48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h7F000000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 10'sd1,   48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 10'sd254, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, -10'sd5,  48'h600000000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result_out, 0);
        check("rst_flags", {overflow_out, underflow_out, inexact_out}, 0);

        // Directed vectors, one at a time
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            apply(vecs[i], 1'b1);
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            lat  = 0;
            seen = 0;
            while (!seen && lat < 10) begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                if (out_valid) seen = 1;
            end
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_result", i), result_out, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {overflow_out, underflow_out, inexact_out},
                  {vecs[i].ov, vecs[i].un, vecs[i].ix});
        end

        // Backpressure: stream vectors 0,1,2,5 with the output stalled
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            apply(vecs[(idx == 3) ? 5 : idx], idx < 4);
            #1;
            if (c >= 2) begin
                check($sformatf("bp_hold_valid_c%0d", c), out_valid, 1);
                check($sformatf("bp_hold_result_c%0d", c), result_out, vecs[0].res);
                check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
            end
            if (in_valid && in_ready) idx++;
        end
        check("bp_accepted_while_stalled", idx, 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            apply(vecs[(idx == 3) ? 5 : idx], idx < 4);
            #1;
            check($sformatf("bp_drain%0d_valid", k), out_valid, 1);
            check($sformatf("bp_drain%0d_result", k), result_out, vecs[(k == 3) ? 5 : k].res);
            if (in_valid && in_ready) idx++;
        end
        check("bp_all_accepted", idx, 4);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_drained", out_valid, 0);

        // Reset with both stages full
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            apply(vecs[idx], idx < 2);
            #1;
            if (in_valid && in_ready) idx++;
        end
        check("rst_fill_count", idx, 2);
        check("rst_fill_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_cycle_no_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result_out, 0);
        check("midrst_flags", {overflow_out, underflow_out, inexact_out}, 0);
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("midrst_no_stale", seen, 0);

        // Randomized stream with random backpressure
        sent = 0; got = 0; cyc = 0; accepted = 0;
        in_valid = 1'b0;
        while ((sent < NR || got < NR) && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (accepted) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid && sent < NR && $urandom_range(0, 3) != 0) begin
                pa  = 48'($urandom_range(24'hFFFFFF, 24'h800000));
                pb  = 48'($urandom_range(24'hFFFFFF, 24'h800000));
                es  = int'($urandom_range(0, 510)) - 127;
                sel = int'($urandom_range(0, 19));
                rv.sign    = 1'($urandom_range(0, 1));
                rv.exp_sum = 10'(es);
                rv.p       = pa * pb;
                rv.nan     = (sel == 0);
                rv.inf     = (sel == 1);
                rv.zero    = (sel == 2);
                apply(rv, 1'b1);
            end
            #1;
            accepted = in_valid && in_ready;
            if (accepted) begin
                sb.push_back(model(sign_in, int'(exp_sum_in), mant_prod_in, nan_in, inf_in, zero_in));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_unexpected_output", 1, 0);
                end else begin
                    expv = sb.pop_front();
                    check($sformatf("rnd%0d", got), {result_out, overflow_out, underflow_out, inexact_out}, expv);
                end
                got++;
            end
        end
        check("rnd_all_received", got, NR);
        check("rnd_scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
